// File: rtl/tt_add_pkg.sv
// ----------------------------------------------------------------------------
// tt_add_pkg
// Shared types for the multi-byte add sequencer and the external 8-bit
// carry-select adder it drives.
//   BYTE_W       : adder datapath width (8)
//   byte_t       : one operand/result byte
//   add_req_t    : operand bundle sent to the adder {a, b, cin}
//   add_rsp_t    : result bundle returned by the adder {sum, cout}
//   seq_state_t  : word position of the sequencer (start / body)
//   signed_ovf() : two's-complement overflow from the MSBs of a, b and sum
// ----------------------------------------------------------------------------
package tt_add_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef struct packed {
        byte_t a;
        byte_t b;
        logic  cin;
    } add_req_t;

    typedef struct packed {
        byte_t sum;
        logic  cout;
    } add_rsp_t;

    typedef enum logic {
        WORD_START = 1'b0,
        WORD_BODY  = 1'b1
    } seq_state_t;

    // Overflow occurs when both addends share a sign and the sum's sign differs.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_out_reg.sv
// ----------------------------------------------------------------------------
// seq_out_reg
// Single-entry valid/ready output register for the add sequencer. It owns the
// upstream ready: a new byte may be accepted whenever the register is empty or
// is being drained in the same cycle (no skid buffer).
//   clk, rst_n           : clock, async active-low reset
//   in_valid_i           : upstream byte pair valid
//   out_ready_i          : downstream accepts the held result
//   in_ready_o           : upstream may transfer this cycle
//   xfer_o               : upstream transfer happens this cycle
//   ld_*_i               : result fields captured on a transfer
//   out_valid_o, out_*_o : registered result stream
// ----------------------------------------------------------------------------
module seq_out_reg
    import tt_add_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             xfer_o,
    input  byte_t            ld_sum_i,
    input  logic [IDX_W-1:0] ld_idx_i,
    input  logic             ld_last_i,
    input  logic             ld_carry_i,
    input  logic             ld_ovf_i,
    input  logic             ld_err_i,
    output logic             out_valid_o,
    output byte_t            out_sum_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             out_carry_o,
    output logic             out_ovf_o,
    output logic             out_err_o
);

    logic             valid_q;
    byte_t            sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             carry_q;
    logic             ovf_q;
    logic             err_q;

    assign in_ready_o = !valid_q || out_ready_i;
    assign xfer_o     = in_valid_i && in_ready_o;

    // Result register: reload on transfer, drop valid on a pure pop, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= 8'h00;
            idx_q   <= '0;
            last_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (xfer_o) begin
            valid_q <= 1'b1;
            sum_q   <= ld_sum_i;
            idx_q   <= ld_idx_i;
            last_q  <= ld_last_i;
            carry_q <= ld_carry_i;
            ovf_q   <= ld_ovf_i;
            err_q   <= ld_err_i;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign out_valid_o = valid_q;
    assign out_sum_o   = sum_q;
    assign out_idx_o   = idx_q;
    assign out_last_o  = last_q;
    assign out_carry_o = carry_q;
    assign out_ovf_o   = ovf_q;
    assign out_err_o   = err_q;

endmodule

// File: rtl/multibyte_add_sequencer.sv
// ----------------------------------------------------------------------------
// multibyte_add_sequencer
// Feeds an external 8-bit adder one byte pair per cycle (LSB first) and chains
// the carry across cycles so an N-byte add/subtract reuses one adder. Each
// accepted byte produces one registered result byte.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : operand stream handshake
//   in_a, in_b                 : operand bytes
//   in_sub                     : subtract select, taken from the first byte
//   in_last                    : most significant byte of the word
//   add_a, add_b, add_cin      : to the external adder
//   add_sum, add_cout          : from the external adder
//   out_valid/out_ready        : result stream handshake
//   out_sum, out_idx, out_last : result byte, its index, end-of-word flag
//   out_carry, out_ovf         : carry-out (1 = no borrow on subtract), signed ovf
//   out_err                    : word hit MAX_BYTES without in_last
// ----------------------------------------------------------------------------
module multibyte_add_sequencer
    import tt_add_pkg::*;
#(
    parameter  int MAX_BYTES = 4,
    localparam int IDX_W     = $clog2(MAX_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  byte_t            in_a,
    input  byte_t            in_b,
    input  logic             in_sub,
    input  logic             in_last,
    output byte_t            add_a,
    output byte_t            add_b,
    output logic             add_cin,
    input  byte_t            add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output byte_t            out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err
);

    seq_state_t       state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q,   sub_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic     first_s;
    logic     sub_eff_s;
    logic     at_max_s;
    logic     term_s;
    logic     ovf_s;
    logic     xfer_s;
    add_req_t req_s;
    add_rsp_t rsp_s;

    assign rsp_s.sum  = add_sum;
    assign rsp_s.cout = add_cout;

    // Adder drive, termination detection and next word-position state.
    always_comb begin
        first_s   = (state_q == WORD_START);
        // in_sub only matters on the first byte; later bytes follow the word.
        sub_eff_s = first_s ? in_sub : sub_q;
        req_s.a   = in_a;
        req_s.b   = sub_eff_s ? ~in_b : in_b;
        // Subtract = A + ~B + 1, so the first byte's carry-in is in_sub.
        req_s.cin = first_s ? in_sub : carry_q;
        at_max_s  = (idx_q == IDX_W'(MAX_BYTES - 1));
        term_s    = in_last || at_max_s;
        ovf_s     = term_s && signed_ovf(req_s.a[BYTE_W-1], req_s.b[BYTE_W-1],
                                         rsp_s.sum[BYTE_W-1]);

        state_d = state_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        if (xfer_s) begin
            if (first_s) begin
                sub_d = in_sub;
            end else begin
                sub_d = sub_q;
            end
            if (term_s) begin
                state_d = WORD_START;
                idx_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = WORD_BODY;
                idx_d   = idx_q + IDX_W'(1'b1);
                carry_d = rsp_s.cout;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Word-position state machine with carry, subtract mode and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WORD_START;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
        end
    end

    assign add_a   = req_s.a;
    assign add_b   = req_s.b;
    assign add_cin = req_s.cin;

    seq_out_reg #(
        .IDX_W (IDX_W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .xfer_o      (xfer_s),
        .ld_sum_i    (rsp_s.sum),
        .ld_idx_i    (idx_q),
        .ld_last_i   (term_s),
        .ld_carry_i  (rsp_s.cout),
        .ld_ovf_i    (ovf_s),
        .ld_err_i    (at_max_s && !in_last),
        .out_valid_o (out_valid),
        .out_sum_o   (out_sum),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .out_carry_o (out_carry),
        .out_ovf_o   (out_ovf),
        .out_err_o   (out_err)
    );

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multibyte_add_sequencer
// Directed bench for multibyte_add_sequencer (MAX_BYTES = 4) with a behavioural
// 8-bit adder closing the add_* loop. Table vectors run back-to-back with
// out_ready = 1; backpressure and mid-word reset are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_multibyte_add_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic       in_last;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [1:0] out_idx;
    logic       out_last;
    logic       out_carry;
    logic       out_ovf;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    multibyte_add_sequencer #(
        .MAX_BYTES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    // External combinational adder.
    logic [8:0] adder_res;
    assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    assign add_sum   = adder_res[7:0];
    assign add_cout  = adder_res[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       last;
        logic [7:0] e_addb;
        logic       e_cin;
        logic [7:0] e_sum;
        logic       e_carry;
        logic [1:0] e_idx;
        logic       e_last;
        logic       e_ovf;
        logic       e_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // a     b      sub   last   addb   cin   sum    carry idx    last  ovf   err
        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h12, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h13, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        // in_sub dropped mid-word must be ignored
        vecs[3]  = '{8'h01, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 8'h80, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        // five bytes without in_last: forced termination at index 3
        vecs[5]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
        // new word: carry from the forced byte must not leak in
        vecs[9]  = '{8'h05, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 8'h06, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        // -128 - 1 overflows
        vecs[10] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b1, 8'h7F, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        // 3-byte 0x7FFFFF + 0x000001 overflows into the sign bit
        vecs[11] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_sub    = 1'b1;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        // ---- reset state ----
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_flags", {28'd0, out_last, out_carry, out_ovf, out_err}, 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_cin_first", 32'(add_cin),   32'd1);
        rst_n = 1'b1;
        after_edge();

        // ---- table vectors, back-to-back ----
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            in_sub   = vecs[i].sub;
            in_last  = vecs[i].last;
            #1;
            check($sformatf("v%0d_add_a", i),   32'(add_a),   32'(vecs[i].a));
            check($sformatf("v%0d_add_b", i),   32'(add_b),   32'(vecs[i].e_addb));
            check($sformatf("v%0d_add_cin", i), 32'(add_cin), 32'(vecs[i].e_cin));
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            after_edge();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_sum", i),   32'(out_sum),   32'(vecs[i].e_sum));
            check($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].e_carry));
            check($sformatf("v%0d_idx", i),   32'(out_idx),   32'(vecs[i].e_idx));
            check($sformatf("v%0d_last", i),  32'(out_last),  32'(vecs[i].e_last));
            check($sformatf("v%0d_ovf", i),   32'(out_ovf),   32'(vecs[i].e_ovf));
            check($sformatf("v%0d_err", i),   32'(out_err),   32'(vecs[i].e_err));
        end
        // finish the 3-byte word started by vecs[11]
        in_a = 8'hFF; in_b = 8'h00; in_sub = 1'b0; in_last = 1'b0;
        after_edge();
        check("w3_b1_sum", 32'(out_sum), 32'h00);
        check("w3_b1_ovf", 32'(out_ovf), 32'd0);
        in_a = 8'h7F; in_b = 8'h00; in_last = 1'b1;
        after_edge();
        check("w3_b2_sum",   32'(out_sum),   32'h80);
        check("w3_b2_idx",   32'(out_idx),   32'd2);
        check("w3_b2_ovf",   32'(out_ovf),   32'd1);
        check("w3_b2_carry", 32'(out_carry), 32'd0);
        in_valid = 1'b0;
        after_edge();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_sum_hold", 32'(out_sum), 32'h80);

        // ---- backpressure: out_ready low for 3 cycles ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 8'h34; in_b = 8'h12; in_sub = 1'b0; in_last = 1'b0;
        after_edge();
        check("bp_first_sum", 32'(out_sum), 32'h46);
        in_a = 8'h01; in_b = 8'h02; in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            after_edge();
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", c),   32'(out_sum),   32'h46);
            check($sformatf("bp%0d_idx", c),   32'(out_idx),   32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        after_edge();
        check("bp_b1_sum",  32'(out_sum),  32'h03);
        check("bp_b1_idx",  32'(out_idx),  32'd1);
        check("bp_b1_last", 32'(out_last), 32'd1);
        in_a = 8'h10; in_b = 8'h20; in_last = 1'b1;
        after_edge();
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_sum",   32'(out_sum),   32'h30);
        check("bp_b2b_idx",   32'(out_idx),   32'd0);
        in_valid = 1'b0;
        after_edge();
        check("bp_pop_valid", 32'(out_valid), 32'd0);

        // ---- async reset mid-word ----
        in_valid = 1'b1;
        in_a = 8'hFF; in_b = 8'h01; in_sub = 1'b0; in_last = 1'b0;
        after_edge();
        check("rw_b0_valid", 32'(out_valid), 32'd1);
        check("rw_b0_carry", 32'(out_carry), 32'd1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rw_valid_drop", 32'(out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_a = 8'h00; in_b = 8'h00; in_sub = 1'b1; in_last = 1'b1;
        #1;
        check("rw_cin_first", 32'(add_cin), 32'd1);
        check("rw_addb_inv",  32'(add_b),   32'hFF);
        after_edge();
        check("rw_idx",   32'(out_idx),   32'd0);
        check("rw_sum",   32'(out_sum),   32'h00);
        check("rw_carry", 32'(out_carry), 32'd1);
        check("rw_last",  32'(out_last),  32'd1);
        in_valid = 1'b0;
        after_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
- Upstream operand sequencer for the team's 8-bit combinational carry-select adder.
- Accepts a stream of byte pairs (LSB first) and drives the adder operands and carry-in.
- Captures the adder's sum/carry and propagates carry across cycles, so an N-byte add or subtract uses one 8-bit adder.
- Presents one registered result byte per accepted input byte on a valid/ready output stream.

Parameters:
- MAX_BYTES, 4, maximum bytes per word (2..16); the byte index width IDX_W = clog2(MAX_BYTES) is a derived localparam.

Ports:
- clk  input  1  clock; all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand byte pair valid.
- in_ready  output  1  sequencer can accept a byte pair.
- in_a  input  8  operand A byte.
- in_b  input  8  operand B byte.
- in_sub  input  1  1 = A-B, 0 = A+B; sampled on the first byte of a word only.
- in_last  input  1  final (most significant) byte of the word.
- add_a  output  8  to adder operand A.
- add_b  output  8  to adder operand B.
- add_cin  output  1  to adder carry-in.
- add_sum  input  8  from adder sum.
- add_cout  input  1  from adder carry-out.
- out_valid  output  1  result byte valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  8  result byte.
- out_idx  output  IDX_W  byte index within the word (0 = LSB).
- out_last  output  1  final byte of the word.
- out_carry  output  1  carry-out of this byte; meaningful when out_last=1 (for subtract, 1 = no borrow).
- out_ovf  output  1  signed overflow; valid on out_last only, else 0.
- out_err  output  1  word exceeded MAX_BYTES and was force-terminated.

Behaviour:
- Reset (async, rst_n=0) values:
  - out_valid=0, out_sum=0, out_idx=0, out_last=0, out_carry=0, out_ovf=0, out_err=0.
  - Internal: first_q=1, carry_q=0, sub_q=0, idx_q=0.
- Reset mid-word discards the partial word. The next accepted byte is treated as first.
- Effective subtract: sub_eff = first_q ? in_sub : sub_q.
- Adder drive (combinational from the current inputs):
  - add_a = in_a.
  - add_b = sub_eff ? ~in_b : in_b.
  - add_cin = first_q ? in_sub : carry_q.
- Handshake:
  - in_ready = !out_valid || out_ready. Only one output register, no skid buffer.
  - Transfer occurs when in_valid && in_ready.
  - in_a/in_b/in_sub/in_last must be stable while in_valid=1.
- On a transfer (registered, 1-cycle latency, result visible the cycle after acceptance):
  - out_sum <= add_sum; out_carry <= add_cout; out_idx <= idx_q; out_valid <= 1.
  - term = in_last || (idx_q == MAX_BYTES-1).
  - out_last <= term.
  - out_err <= (idx_q == MAX_BYTES-1) && !in_last.
  - out_ovf <= term && (in_a[7] == add_b[7]) && (add_sum[7] != in_a[7]).
  - If first_q: sub_q <= in_sub.
  - If term: first_q <= 1, idx_q <= 0, carry_q <= 0.
  - Else: first_q <= 0, idx_q <= idx_q+1, carry_q <= add_cout.
- Output with no transfer: if out_ready && out_valid, then out_valid <= 0. The other out_* registers hold their values.
- Simultaneous output pop and new input accept in the same cycle: the output is reloaded and out_valid stays 1. Full throughput is 1 byte/cycle.
- Backpressure: while out_valid && !out_ready, in_ready=0. All state and outputs hold.
- in_sub toggling mid-word is ignored; sub_q governs the word.
- Single-byte word (in_last on first byte): carry-in = in_sub; out_idx=0, out_last=1.
- Bytes arriving after a forced termination start a new word.
- State machine: two states encoded by first_q, WORD_START (first_q=1) and WORD_BODY (first_q=0).
  - WORD_START -> WORD_BODY on a transfer with !term.
  - WORD_BODY -> WORD_START on a transfer with term.

Decomposition:
- Shared package tt_add_pkg holds:
  - BYTE_W = 8.
  - Typedef byte_t.
  - Typedef add_req_t {a, b, cin}.
  - Typedef add_rsp_t {sum, cout}.
- One natural sub-module: seq_out_reg. It is the valid/ready output register holding sum/idx/last/carry/ovf/err, and owns the in_ready logic.
- The adder itself stays external. The top level wires add_* to it.

Test Plan:
- 16-bit add 0x12FF + 0x0001, 2 bytes, in_sub=0:
  - Byte 0: out_sum=0x00, out_carry=1, idx=0.
  - Byte 1: out_sum=0x13, out_last=1, out_carry=0, out_ovf=0.
- 16-bit subtract 0x0100 - 0x0001, in_sub=1:
  - Byte 0: add_cin=1, add_b=0xFE, out_sum=0xFF.
  - Byte 1: out_sum=0x00, out_carry=1 (no borrow), out_ovf=0.
- Single-byte signed overflow 0x7F + 0x01, in_last=1:
  - out_sum=0x80, out_ovf=1, out_carry=0, out_last=1.
- MAX_BYTES=4, five bytes with no in_last:
  - Byte 3: out_last=1, out_err=1.
  - Byte 4: out_idx=0, and its add_cin=in_sub (new word).
- out_ready held 0 for 3 cycles after the first result:
  - in_ready=0 throughout; out_sum stable.
  - Releasing out_ready with in_valid=1 yields back-to-back transfers at 1/cycle.
- Assert rst_n=0 asynchronously after byte 0 of a 2-byte word:
  - out_valid drops immediately.
  - The next byte uses add_cin=in_sub and reports out_idx=0.
